// File: rtl/fp_addsub_prestage.sv
// Two-stage FP32 add/sub operand pre-stage: capture, then zero-classify and magnitude-order.
// Optional FP_DENORM_FLUSH_EN flushes exp==0 operands to signed zero; `small` is reserved, hence small_o.
module fp_addsub_prestage #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     outA,
  output logic [W-1:0]     outB,
  output logic             op_o,
  output logic             zeroA,
  output logic             zeroB,
  output logic [W-1:0]     big,
  output logic [W-1:0]     small_o,
  output logic [EXP_W-1:0] exp_diff,
  output logic             eff_sub,
  output logic             swap
);

  logic             init_q, init_d;
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic             s1_op_q, s1_op_d;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_a_q, out_a_d;
  logic [W-1:0]     out_b_q, out_b_d;
  logic             op_o_q, op_o_d;
  logic             zero_a_q, zero_a_d;
  logic             zero_b_q, zero_b_d;
  logic [W-1:0]     big_q, big_d;
  logic [W-1:0]     small_q, small_d;
  logic [EXP_W-1:0] exp_diff_q, exp_diff_d;
  logic             eff_sub_q, eff_sub_d;
  logic             swap_q, swap_d;

  logic             s2_adv;
  logic             in_ready_w;
  logic             accept;

  logic [W-1:0]     fa, fb;
  logic             za, zb;
  logic             sw;
  logic [W-1:0]     bg, sm;

  // Classification of the S1 contents feeding the S2 registers.
  always_comb begin
    fa = s1_a_q;
    fb = s1_b_q;
`ifdef FP_DENORM_FLUSH_EN
    za = (s1_a_q[W-2:MAN_W] == '0);
    zb = (s1_b_q[W-2:MAN_W] == '0);
    if (za) fa = {s1_a_q[W-1], {(W-1){1'b0}}};
    if (zb) fb = {s1_b_q[W-1], {(W-1){1'b0}}};
`else
    za = (s1_a_q[W-2:0] == '0);
    zb = (s1_b_q[W-2:0] == '0);
`endif
    sw = (fb[W-2:0] > fa[W-2:0]);
    bg = sw ? fb : fa;
    sm = sw ? fa : fb;
  end

  always_comb begin
    s2_adv     = !out_valid_q || out_ready;
    in_ready_w = init_q && (!s1_valid_q || s2_adv);
    accept     = in_valid && in_ready_w;
    init_d     = 1'b1;

    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_a_d     = inA;
      s1_b_d     = inB;
      s1_op_d    = op;
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    op_o_d      = op_o_q;
    zero_a_d    = zero_a_q;
    zero_b_d    = zero_b_q;
    big_d       = big_q;
    small_d     = small_q;
    exp_diff_d  = exp_diff_q;
    eff_sub_d   = eff_sub_q;
    swap_d      = swap_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_a_d    = fa;
        out_b_d    = fb;
        op_o_d     = s1_op_q;
        zero_a_d   = za;
        zero_b_d   = zb;
        big_d      = bg;
        small_d    = sm;
        // big.exp >= small.exp by construction, so this never wraps.
        exp_diff_d = bg[W-2:MAN_W] - sm[W-2:MAN_W];
        eff_sub_d  = s1_op_q ^ s1_a_q[W-1] ^ s1_b_q[W-1];
        swap_d     = sw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      op_o_q      <= 1'b0;
      zero_a_q    <= 1'b0;
      zero_b_q    <= 1'b0;
      big_q       <= '0;
      small_q     <= '0;
      exp_diff_q  <= '0;
      eff_sub_q   <= 1'b0;
      swap_q      <= 1'b0;
    end else begin
      init_q      <= init_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      op_o_q      <= op_o_d;
      zero_a_q    <= zero_a_d;
      zero_b_q    <= zero_b_d;
      big_q       <= big_d;
      small_q     <= small_d;
      exp_diff_q  <= exp_diff_d;
      eff_sub_q   <= eff_sub_d;
      swap_q      <= swap_d;
    end
  end

  assign in_ready  = in_ready_w;
  assign out_valid = out_valid_q;
  assign outA      = out_a_q;
  assign outB      = out_b_q;
  assign op_o      = op_o_q;
  assign zeroA     = zero_a_q;
  assign zeroB     = zero_b_q;
  assign big       = big_q;
  assign small_o   = small_q;
  assign exp_diff  = exp_diff_q;
  assign eff_sub   = eff_sub_q;
  assign swap      = swap_q;

endmodule
